// File: rtl/ni_pkg.sv
// Shared types and helpers for the NoC network-interface transmitter.
// Holds the FSM state type, the 1-of-4 digit encoder and the head-flit digit map.
package ni_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEAD_SET = 3'd1,
    HEAD_RST = 3'd2,
    BODY_SET = 3'd3,
    BODY_RST = 3'd4,
    EOF_SET  = 3'd5,
    EOF_RST  = 3'd6
  } ni_state_e;

  localparam int X_LO = 0;
  localparam int X_HI = 1;
  localparam int Y_LO = 2;
  localparam int Y_HI = 3;

  // One digit to its rails, returned as {o0, o1, o2, o3}.
  function automatic logic [3:0] enc1of4(input logic [1:0] data);
    logic [3:0] rails;
    case (data)
      2'd0:    rails = 4'b1000;
      2'd1:    rails = 4'b0100;
      2'd2:    rails = 4'b0010;
      2'd3:    rails = 4'b0001;
      default: rails = 4'b0000;
    endcase
    return rails;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FD-entry flit FIFO with registered ready (not full) and empty flags.
// ready_o is low while reset is asserted so the core cannot push into a resetting link.
module ni_fifo #(
  parameter int W  = 25,
  parameter int FD = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         ready_o,
  output logic         empty_o,
  output logic         empty_nx_o,
  output logic [W-1:0] rdata_o
);

  localparam int AW = (FD > 1) ? $clog2(FD) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FD);

  logic [W-1:0]  mem_q [FD];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          empty_q, empty_d;
  logic          do_push_s, do_pop_s;

  assign do_push_s = push_i & ready_q;
  assign do_pop_s  = pop_i & ~empty_q;

  // Next pointers, occupancy and the flags derived from the next occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!do_push_s && do_pop_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    ready_d = (cnt_d != CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  // Control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[rptr_q];
  assign ready_o    = ready_q;
  assign empty_o    = empty_q;
  assign empty_nx_o = empty_d;

endmodule

// File: rtl/ni_tx.sv
// NoC network-interface transmitter: buffers core flits and emits them as 1-of-4
// return-to-zero four-phase tokens (head, body..., eof) toward a router input port.
module ni_tx
  import ni_pkg::*;
#(
  parameter int DW = 16,
  parameter int FD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [3:0]      in_dx,
  input  logic [3:0]      in_dy,
  input  logic            in_last,
  output logic [DW/2-1:0] o0,
  output logic [DW/2-1:0] o1,
  output logic [DW/2-1:0] o2,
  output logic [DW/2-1:0] o3,
  output logic            o4,
  input  logic            ia,
  output logic            busy
);

  localparam int SCN = DW / 2;
  localparam int EW  = DW + 9;

  logic [1:0]       sync_q;
  logic             ack_s;
  logic             first_q;
  logic [3:0]       dx_q, dy_q;
  logic             push_s, pop_s;
  logic             fifo_empty_s, fifo_empty_nx_s;
  logic [EW-1:0]    wentry_s, fentry_s;
  logic [DW-1:0]    f_data_s;
  logic [3:0]       f_dx_s, f_dy_s;
  logic             f_last_s;
  logic [DW-1:0]    head_w_s;
  logic [4*SCN-1:0] head_tok_s, data_tok_s;
  logic [4*SCN-1:0] rails_q, rails_d;
  logic             o4_q, o4_d;
  logic             lastp_q, lastp_d;
  logic             busy_q, busy_d;
  ni_state_e        state_q, state_d;

  assign push_s   = in_valid & in_ready;
  assign wentry_s = {in_data, (first_q ? in_dx : dx_q), (first_q ? in_dy : dy_q), in_last};

  ni_fifo #(
    .W  (EW),
    .FD (FD)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push_s),
    .wdata_i    (wentry_s),
    .pop_i      (pop_s),
    .ready_o    (in_ready),
    .empty_o    (fifo_empty_s),
    .empty_nx_o (fifo_empty_nx_s),
    .rdata_o    (fentry_s)
  );

  assign {f_data_s, f_dx_s, f_dy_s, f_last_s} = fentry_s;

  // Frame tracking on the write side: coordinates of non-first flits are replaced by the frame's own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b1;
      dx_q    <= 4'd0;
      dy_q    <= 4'd0;
    end else if (push_s) begin
      first_q <= in_last;
      if (first_q) begin
        dx_q <= in_dx;
        dy_q <= in_dy;
      end
    end
  end

  // Two-flop synchronizer for the router acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ia};
    end
  end

  assign ack_s = sync_q[1];

  // Route word of the front entry; digits above the coordinates stay zero.
  always_comb begin
    head_w_s                 = '0;
    head_w_s[2*X_LO +: 2]    = f_dx_s[1:0];
    head_w_s[2*X_HI +: 2]    = f_dx_s[3:2];
    head_w_s[2*Y_LO +: 2]    = f_dy_s[1:0];
    head_w_s[2*Y_HI +: 2]    = f_dy_s[3:2];
  end

  // Rail images of the head and data words, packed as {o3, o2, o1, o0}.
  always_comb begin
    head_tok_s = '0;
    data_tok_s = '0;
    for (int k = 0; k < SCN; k++) begin
      {head_tok_s[k], head_tok_s[SCN+k], head_tok_s[2*SCN+k], head_tok_s[3*SCN+k]} =
        enc1of4(head_w_s[2*k +: 2]);
      {data_tok_s[k], data_tok_s[SCN+k], data_tok_s[2*SCN+k], data_tok_s[3*SCN+k]} =
        enc1of4(f_data_s[2*k +: 2]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each phase advances only on the synchronized ack level it waits for.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !ack_s) state_d = HEAD_SET;
        else                         state_d = IDLE;
      end
      HEAD_SET: begin
        if (ack_s) state_d = HEAD_RST;
        else       state_d = HEAD_SET;
      end
      HEAD_RST: begin
        if (!ack_s) state_d = BODY_SET;
        else        state_d = HEAD_RST;
      end
      BODY_SET: begin
        if (ack_s) state_d = BODY_RST;
        else       state_d = BODY_SET;
      end
      BODY_RST: begin
        if (!ack_s) begin
          if (lastp_q)            state_d = EOF_SET;
          else if (!fifo_empty_s) state_d = BODY_SET;
          else                    state_d = BODY_RST;
        end else begin
          state_d = BODY_RST;
        end
      end
      EOF_SET: begin
        if (ack_s) state_d = EOF_RST;
        else       state_d = EOF_SET;
      end
      EOF_RST: begin
        if (!ack_s) state_d = IDLE;
        else        state_d = EOF_RST;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: rails load or clear only on the transition that starts a phase.
  always_comb begin
    rails_d = rails_q;
    o4_d    = o4_q;
    lastp_d = lastp_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == HEAD_SET) rails_d = head_tok_s;
        else                     rails_d = rails_q;
      end
      HEAD_SET: begin
        if (state_d == HEAD_RST) rails_d = '0;
        else                     rails_d = rails_q;
      end
      HEAD_RST: begin
        if (state_d == BODY_SET) rails_d = data_tok_s;
        else                     rails_d = rails_q;
      end
      BODY_SET: begin
        if (state_d == BODY_RST) begin
          rails_d = '0;
          pop_s   = 1'b1;
          lastp_d = f_last_s;
        end else begin
          rails_d = rails_q;
        end
      end
      BODY_RST: begin
        if (state_d == BODY_SET)     rails_d = data_tok_s;
        else if (state_d == EOF_SET) o4_d    = 1'b1;
        else                         rails_d = rails_q;
      end
      EOF_SET: begin
        if (state_d == EOF_RST) o4_d = 1'b0;
        else                    o4_d = o4_q;
      end
      default: begin
        rails_d = rails_q;
        o4_d    = o4_q;
      end
    endcase
    busy_d = (state_d != IDLE) || !fifo_empty_nx_s;
  end

  // Output flops so every rail changes cleanly on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rails_q <= '0;
      o4_q    <= 1'b0;
      lastp_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rails_q <= rails_d;
      o4_q    <= o4_d;
      lastp_q <= lastp_d;
      busy_q  <= busy_d;
    end
  end

  assign o0   = rails_q[0     +: SCN];
  assign o1   = rails_q[SCN   +: SCN];
  assign o2   = rails_q[2*SCN +: SCN];
  assign o3   = rails_q[3*SCN +: SCN];
  assign o4   = o4_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ni_tx.sv
// Randomized bench for ni_tx: a router-side responder records every token and the
// token stream is compared against a frame-level reference built from the encoding rules.
module tb_ni_tx;

  localparam int DW  = 16;
  localparam int FD  = 2;
  localparam int SCN = DW / 2;
  localparam int TW  = 4 * SCN + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [3:0]     in_dx, in_dy;
  logic           in_last;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic           o4;
  logic           ia;
  logic           busy;
  logic [TW-1:0]  cur;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   oh_err   = 0;
  int   hold_err = 0;
  bit   resp_en  = 1'b0;
  logic ia_forced = 1'b0;
  int   dly = 0;
  bit   m_first = 1'b1;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];

  assign cur = {o4, o3, o2, o1, o0};

  always #5 clk = ~clk;

  ni_tx #(.DW(DW), .FD(FD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dx    (in_dx),
    .in_dy    (in_dy),
    .in_last  (in_last),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .ia       (ia),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Token image of a word: digit k with value v lights rail v of sub-channel k.
  function automatic logic [TW-1:0] tok_of(input int unsigned word);
    logic [TW-1:0] t;
    int unsigned v;
    t = '0;
    for (int k = 0; k < SCN; k++) begin
      v = (word >> (2 * k)) % 4;
      t[v * SCN + k] = 1'b1;
    end
    return t;
  endfunction

  function automatic logic [TW-1:0] eof_tok();
    logic [TW-1:0] t;
    t = '0;
    t[TW-1] = 1'b1;
    return t;
  endfunction

  task automatic send_flit(input logic [DW-1:0] d, input logic [3:0] dx, input logic [3:0] dy,
                           input logic last);
    int waited;
    if (m_first) exp_q.push_back(tok_of(16 * int'(dy) + int'(dx)));
    exp_q.push_back(tok_of(int'(d)));
    if (last) exp_q.push_back(eof_tok());
    m_first = last;
    in_data  = d;
    in_dx    = dx;
    in_dy    = dy;
    in_last  = last;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("send_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int stable;
    int n;
    stable = 0;
    n = 0;
    while (stable < 4 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (!busy && !ia && cur == '0) stable++;
      else stable = 0;
    end
    check_eq("idle_reached", (stable >= 4) ? 1 : 0, 1);
  endtask

  task automatic wait_obs(input int want, input int budget);
    int n;
    n = 0;
    while (obs_q.size() < want && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("obs_count", (obs_q.size() >= want) ? 1 : 0, 1);
  endtask

  task automatic cmp_frames(input string tag);
    check_eq({tag, "_ntok"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_eq(tag, obs_q[i], exp_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Router model: acks each token / spacer after dly cycles and polices the handshake rules.
  initial begin
    int wcnt;
    int on;
    int nr;
    logic [TW-1:0] cap;
    ia   = 1'b0;
    wcnt = 0;
    cap  = '0;
    forever begin
      @(posedge clk); #1;
      on = 0;
      for (int k = 0; k < SCN; k++) begin
        nr = int'(o0[k]) + int'(o1[k]) + int'(o2[k]) + int'(o3[k]);
        if (nr > 1) oh_err++;
        if (nr > 0) on++;
      end
      if (on != 0 && on != SCN) oh_err++;
      if (o4 && on != 0) oh_err++;
      if (!resp_en) begin
        ia   = ia_forced;
        wcnt = 0;
      end else if (!ia) begin
        if (cur != '0) begin
          if (wcnt == 0) begin
            cap = cur;
            obs_q.push_back(cur);
          end else if (cur != cap) begin
            hold_err++;
          end
          if (wcnt >= dly) begin
            ia   = 1'b1;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else if (wcnt > 0) begin
          hold_err++;
          wcnt = 0;
        end
      end else begin
        if (cur == '0) begin
          if (wcnt >= dly) begin
            ia   = 1'b0;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else if (wcnt > 0) begin
          hold_err++;
          wcnt = 0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int len;
    int seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dx    = 4'd0;
    in_dy    = 4'd0;
    in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rails", cur, 0);
    check_eq("rst_rdy", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rdy_after_rst", in_ready, 1);
    resp_en = 1'b1;

    // Single-flit frame with the documented rail images.
    dly = 3;
    send_flit(16'h00E4, 4'd2, 4'd3, 1'b1);
    check_eq("launch_pre", cur, 0);
    @(posedge clk); #1;
    check_eq("head_lit", cur, {1'b0, 8'h04, 8'h01, 8'h00, 8'hFA});
    wait_idle(400);
    if (obs_q.size() > 1) check_eq("body_lit", obs_q[1], {1'b0, 8'h08, 8'h04, 8'h02, 8'hF1});
    else                  check_eq("body_lit_count", obs_q.size(), 2);
    cmp_frames("single");

    // Three-flit frame with slow ack; FIFO fills after two flits.
    dly = 10;
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    check_eq("full_rdy", in_ready, 0);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    wait_idle(2000);
    cmp_frames("slow3");

    // Back-to-back random frames; coordinates on non-first flits are noise.
    for (int f = 0; f < 8; f++) begin
      dly = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        d = DW'($urandom);
        send_flit(d, 4'($urandom), 4'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
      end
    end
    wait_idle(3000);
    cmp_frames("b2b");

    // Feed stalls after the first flit of a frame.
    dly = 1;
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    wait_obs(2, 300);
    repeat (30) @(posedge clk);
    #1;
    check_eq("underrun_rails", cur, 0);
    check_eq("underrun_busy", busy, 1);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    wait_idle(400);
    cmp_frames("underrun");

    // Reset while a body token is on the wires.
    dly = 2;
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    wait_obs(2, 300);
    resp_en   = 1'b0;
    ia_forced = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_rails", cur, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rdy", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_first = 1'b1;
    resp_en = 1'b1;
    dly     = $urandom_range(0, 3);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    wait_idle(600);
    cmp_frames("post_rst");

    // ia held high across reset release: nothing may launch until it falls.
    resp_en   = 1'b0;
    ia_forced = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_first = 1'b1;
    send_flit(DW'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cur != '0) seen++;
    end
    check_eq("ia_high_hold", seen, 0);
    dly     = 2;
    resp_en = 1'b1;
    wait_idle(600);
    cmp_frames("ia_high");

    check_eq("onehot_viol", oh_err, 0);
    check_eq("handshake_viol", hold_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
